dma_access_arbiter: RTL and testbench
=====================================

// Module: dma_access_arbiter
// PURPOSE
//  Shares the single MSP430 DMA port (dma_addr/dma_en) between two DMA requesters with round-robin bursts.
//  Blocks any beat that targets the secure-key region (SDATA) or the counter region (CTR).
//  Locks DMA out while the PC is inside SW-Att code, so attestation runs without DMA activity.
//  Sits between the DMA masters and the core's DMA port, upstream of the hardware DMA monitor, which should then never trip.
// PARAMETERS
//  SDATA_BASE    16'hA000  secure data region base
//  SDATA_SIZE    16'h1000  secure data region size (bytes)
//  CTR_BASE      16'h9000  counter region base
//  CTR_SIZE      16'h001F  counter region size
//  SCODE_BASE    16'hE000  SW-Att code base
//  SCODE_SIZE    16'h1000  SW-Att code size
//  RESET_HANDLER 16'h0000  PC value that releases FAULT
//  MAX_BURST     4'd8      max beats per grant before forced re-arbitration (1..15)
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous reset, active-low
//  pc         in   16  current CPU program counter
//  req0       in   1   requester 0 beat request (level, held per beat)
//  addr0      in   16  requester 0 beat address
//  req1       in   1   requester 1 beat request
//  addr1      in   16  requester 1 beat address
//  gnt0       out  1   requester 0 owns the port (registered)
//  gnt1       out  1   requester 1 owns the port (registered)
//  dma_en     out  1   beat forwarded to the core this cycle (combinational)
//  dma_addr   out  16  forwarded address; 16'h0000 when dma_en=0
//  dma_fault  out  1   sticky: protected access attempted (registered)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, gnt0=gnt1=0, dma_fault=0, beat_cnt=0, last=1 (so req0 wins first).
//  Decodes (all comb, half-open [BASE, BASE+SIZE)): in_scode(pc); prot(a) = in SDATA or in CTR.
//  States: IDLE, OWN0, OWN1, LOCK, FAULT.
//  IDLE: if in_scode -> LOCK. Else if req0&req1 -> grant !last. Else grant the single requester.
//        Grant is registered: the gnt is high one cycle after the req is sampled; beat_cnt=0.
//  OWNx: dma_en = reqx & !prot(addrx) & !in_scode; dma_addr = addrx when dma_en is high.
//        Each cycle with dma_en high: beat_cnt++.
//        The grant is released (-> IDLE, last=x, gnt low next cycle) when either:
//          - reqx drops, or
//          - a beat completes with beat_cnt == MAX_BURST-1.
//        From IDLE the other requester wins if it is pending.
//  Protection: reqx & prot(addrx) while in OWNx gives:
//          - same cycle: dma_en=0;
//          - next edge: state=FAULT, gnts=0, dma_fault=1.
//  Lock: in_scode in OWNx gives:
//          - same cycle: dma_en=0;
//          - next edge: state=LOCK, gnts=0.
//        LOCK: no grants. Leave to IDLE on the first cycle in which in_scode is false.
//  FAULT: no grants, dma_en=0. Leave to IDLE with dma_fault cleared when pc==RESET_HANDLER
//         and no pending req addresses a protected region.
//  Priority on simultaneous events: fault > lock > burst-end > normal.
//  A fault taken during LOCK entry still sets FAULT.
//  req-only (no gnt) requesters never reach dma_en.
//  dma_en is never high in IDLE, LOCK or FAULT, or in the same cycle that in_scode or prot is true.
//  Reset mid-burst: outputs drop immediately (async). A requester must re-request.
// STRUCTURE
//  Package vrased_mem_map_pkg: region BASE/SIZE constants, RESET_HANDLER, and the state encoding localparams.
//  One sub-module addr_range_chk (BASE, SIZE; addr -> hit), instantiated for SDATA/CTR x2 requesters and SCODE on pc.
//  Arbiter FSM, beat counter and round-robin bit live in the top level.
// TESTING
//  1. req0=1, addr0=16'h2000 for 10 cycles, MAX_BURST=8
//     -> gnt0 at cycle 1; 8 beats with dma_en=1; gnt0 drops; re-granted after 1 IDLE cycle.
//  2. req0=req1=1 both held -> gnt alternates 0,1,0 with an 8-beat burst each; first grant goes to 0.
//  3. OWN1, addr1=16'hA004
//     -> dma_en=0 that cycle; next cycle dma_fault=1, gnt1=0.
//     -> stays FAULT until pc=16'h0000 with clean reqs, then IDLE and dma_fault=0.
//  4. OWN0 mid-burst, pc=16'hE010
//     -> dma_en=0 same cycle; LOCK next cycle.
//     -> pc=16'h4000 returns to IDLE; req0 regranted.
//  5. Same cycle addr0=16'h9004 and pc=16'hE000 -> FAULT (not LOCK); dma_fault=1.
//  6. reset_n=0 during a beat -> gnt0, dma_en, dma_fault all 0 before the next clk edge; last=1.

Source files
------------

// File: rtl/dma_access_arbiter_pkg.sv
// vrased_mem_map_pkg: protected memory map, reset handler and arbiter state encoding
package vrased_mem_map_pkg;
  localparam logic [15:0] SDATA_BASE    = 16'hA000;
  localparam logic [15:0] SDATA_SIZE    = 16'h1000;
  localparam logic [15:0] CTR_BASE      = 16'h9000;
  localparam logic [15:0] CTR_SIZE      = 16'h001F;
  localparam logic [15:0] SCODE_BASE    = 16'hE000;
  localparam logic [15:0] SCODE_SIZE    = 16'h1000;
  localparam logic [15:0] RESET_HANDLER = 16'h0000;
  localparam logic [3:0]  MAX_BURST     = 4'd8;
  typedef enum logic [2:0] {IDLE, OWN0, OWN1, LOCK, FAULT} state_t;
endpackage

// File: rtl/dma_access_arbiter_if.sv
// dma_access_arbiter_if: requester/PC inputs and arbitrated DMA port outputs
interface dma_access_arbiter_if;
  logic [15:0] pc;
  logic        req0;
  logic [15:0] addr0;
  logic        req1;
  logic [15:0] addr1;
  logic        gnt0;
  logic        gnt1;
  logic        dma_en;
  logic [15:0] dma_addr;
  logic        dma_fault;
  modport master (output pc, req0, addr0, req1, addr1, input gnt0, gnt1, dma_en, dma_addr, dma_fault);
  modport slave  (input pc, req0, addr0, req1, addr1, output gnt0, gnt1, dma_en, dma_addr, dma_fault);
endinterface

// File: rtl/dma_access_arbiter_addr_range_chk.sv
// addr_range_chk: half-open [BASE, BASE+SIZE) hit test, widened so the top bound cannot wrap
module addr_range_chk #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0001
) (
  input  logic [15:0] addr,
  output logic        hit
);
  assign hit = ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < ({1'b0, BASE} + {1'b0, SIZE}));
endmodule

// File: rtl/dma_access_arbiter.sv
// dma_access_arbiter: round-robin burst arbiter for the DMA port with SDATA/CTR blocking and SW-Att lockout
module dma_access_arbiter
  import vrased_mem_map_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  dma_access_arbiter_if.slave bus
);
  logic sd0, ct0, sd1, ct1, in_scode;
  logic prot0, prot1, sel1, req_s, prot_s, own, dma_en;
  logic [15:0] addr_s;
  state_t state, state_nxt;
  logic last, last_nxt;
  logic [3:0] cnt, cnt_nxt;
  addr_range_chk #(.BASE(SDATA_BASE), .SIZE(SDATA_SIZE)) u_sd0 (.addr(bus.addr0), .hit(sd0));
  addr_range_chk #(.BASE(CTR_BASE),   .SIZE(CTR_SIZE))   u_ct0 (.addr(bus.addr0), .hit(ct0));
  addr_range_chk #(.BASE(SDATA_BASE), .SIZE(SDATA_SIZE)) u_sd1 (.addr(bus.addr1), .hit(sd1));
  addr_range_chk #(.BASE(CTR_BASE),   .SIZE(CTR_SIZE))   u_ct1 (.addr(bus.addr1), .hit(ct1));
  addr_range_chk #(.BASE(SCODE_BASE), .SIZE(SCODE_SIZE)) u_sc  (.addr(bus.pc),    .hit(in_scode));
  assign prot0  = sd0 | ct0;
  assign prot1  = sd1 | ct1;
  assign sel1   = state == OWN1;
  assign own    = state == OWN0 || state == OWN1;
  assign req_s  = sel1 ? bus.req1 : bus.req0;
  assign prot_s = sel1 ? prot1 : prot0;
  assign addr_s = sel1 ? bus.addr1 : bus.addr0;
  assign dma_en = own & req_s & ~prot_s & ~in_scode;
  assign bus.dma_en    = dma_en;
  assign bus.dma_addr  = dma_en ? addr_s : 16'h0000;
  assign bus.gnt0      = state == OWN0;
  assign bus.gnt1      = state == OWN1;
  assign bus.dma_fault = state == FAULT;
  // State, round-robin bit and beat counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end
  // Next state: fault beats lock, lock beats burst end, burst end beats continuing
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (in_scode) state_nxt = LOCK;
        else if (bus.req0 && bus.req1) state_nxt = last ? OWN0 : OWN1;
        else if (bus.req0) state_nxt = OWN0;
        else if (bus.req1) state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (req_s && prot_s) state_nxt = FAULT;
        else if (in_scode) state_nxt = LOCK;
        else if (!req_s || (dma_en && cnt == MAX_BURST - 4'd1)) begin
          state_nxt = IDLE;
          last_nxt  = sel1;
        end else cnt_nxt = cnt + {3'b000, dma_en};
      end
      LOCK:    state_nxt = in_scode ? LOCK : IDLE;
      FAULT:   state_nxt = (bus.pc == RESET_HANDLER && !(bus.req0 && prot0) && !(bus.req1 && prot1)) ? IDLE : FAULT;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_access_arbiter.sv
// tb_dma_access_arbiter: directed scenarios plus random traffic checked against a behavioural model
module tb_dma_access_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int m_own, m_last, m_beats;
  bit m_lock, m_fault;
  bit rr0, rr1;
  logic [15:0] bnd [6] = '{16'h9FFF, 16'hB000, 16'h901F, 16'h8FFF, 16'hA000, 16'h901E};
  dma_access_arbiter_if bus();
  dma_access_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit in_rng(int a, int base, int size);
    return a >= base && a < base + size;
  endfunction
  function automatic bit prot(int a);
    return in_rng(a, 'hA000, 'h1000) || in_rng(a, 'h9000, 'h1F);
  endfunction
  function automatic bit scode(int p);
    return in_rng(p, 'hE000, 'h1000);
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = -1;
    m_last = 1;
    m_beats = 0;
    m_lock = 0;
    m_fault = 0;
  endtask
  task automatic do_reset();
    bus.req0 = 0; bus.req1 = 0; bus.addr0 = 0; bus.addr1 = 0; bus.pc = 16'h4000;
    reset_n = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask
  task automatic step(input bit r0, input logic [15:0] a0, input bit r1, input logic [15:0] a1, input logic [15:0] p);
    bit r, pr, sc, en;
    int a;
    bus.req0 = r0; bus.addr0 = a0; bus.req1 = r1; bus.addr1 = a1; bus.pc = p;
    #1;
    sc = scode(int'(p));
    r = (m_own == 1) ? r1 : r0;
    a = (m_own == 1) ? int'(a1) : int'(a0);
    pr = prot(a);
    en = m_own >= 0 && r && !pr && !sc;
    check("gnt0", int'(bus.gnt0), int'(m_own == 0));
    check("gnt1", int'(bus.gnt1), int'(m_own == 1));
    check("dma_en", int'(bus.dma_en), int'(en));
    check("dma_addr", int'(bus.dma_addr), en ? a : 0);
    check("dma_fault", int'(bus.dma_fault), int'(m_fault));
    if (bus.dma_en) en_cnt++;
    @(posedge clk);
    if (m_fault) begin
      if (p == 16'h0000 && !(r0 && prot(int'(a0))) && !(r1 && prot(int'(a1)))) m_fault = 0;
    end else if (m_lock) begin
      if (!sc) m_lock = 0;
    end else if (m_own < 0) begin
      m_beats = 0;
      if (sc) m_lock = 1;
      else if (r0 && r1) m_own = (m_last == 1) ? 0 : 1;
      else if (r0) m_own = 0;
      else if (r1) m_own = 1;
    end else if (r && pr) begin
      m_fault = 1; m_own = -1;
    end else if (sc) begin
      m_lock = 1; m_own = -1;
    end else if (!r) begin
      m_last = m_own; m_own = -1;
    end else begin
      m_beats++;
      if (m_beats == 8) begin
        m_last = m_own; m_own = -1;
      end
    end
    @(negedge clk);
  endtask
  function automatic logic [15:0] rnd_addr();
    int k = $urandom_range(0, 39);
    if (k == 0) return 16'hA000 + 16'($urandom_range(0, 'hFFF));
    if (k == 1) return 16'h9000 + 16'($urandom_range(0, 'h1E));
    if (k == 2) return bnd[$urandom_range(0, 5)];
    return 16'($urandom_range(0, 'h8FFF));
  endfunction
  function automatic logic [15:0] rnd_pc();
    int k = $urandom_range(0, 29);
    if (k == 0) return 16'hE000 + 16'($urandom_range(0, 'hFFF));
    if (k == 1) return ($urandom_range(0, 1) != 0) ? 16'hDFFF : 16'hF000;
    if (k < 9) return 16'h0000;
    return 16'($urandom_range(1, 'hDFFF));
  endfunction
  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.addr0 = 0; bus.addr1 = 0; bus.pc = 16'h4000;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, 16'h2000, 0, 16'h0, 16'h4000);
    check("t1_beats", en_cnt, 8);
    step(1, 16'h2000, 0, 16'h0, 16'h4000);
    check("t1_regrant", int'(bus.gnt0), 1);
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 16'h2100, 1, 16'h3100, 16'h4000);
    do_reset();
    step(0, 16'h0, 1, 16'h3000, 16'h4000);
    step(0, 16'h0, 1, 16'h3002, 16'h4000);
    step(0, 16'h0, 1, 16'hA004, 16'h4000);
    check("t3_fault", int'(bus.dma_fault), 1);
    step(0, 16'h0, 1, 16'hA004, 16'h0000);
    step(0, 16'h0, 0, 16'h0, 16'h1234);
    step(0, 16'h0, 0, 16'h0, 16'h0000);
    check("t3_clear", int'(bus.dma_fault), 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'h2000, 0, 16'h0, 16'h4000);
    for (int i = 0; i < 3; i++) step(1, 16'h2000, 0, 16'h0, 16'hE010);
    for (int i = 0; i < 3; i++) step(1, 16'h2000, 0, 16'h0, 16'h4000);
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 16'h2000, 0, 16'h0, 16'h4000);
    step(1, 16'h9004, 0, 16'h0, 16'hE000);
    check("t5_fault", int'(bus.dma_fault), 1);
    step(0, 16'h0, 0, 16'h0, 16'hE000);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'h2000, 1, 16'h3000, 16'h4000);
    #3;
    reset_n = 0;
    #1;
    check("t6_gnt0", int'(bus.gnt0), 0);
    check("t6_en", int'(bus.dma_en), 0);
    check("t6_fault", int'(bus.dma_fault), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) step(1, 16'h2000, 1, 16'h3000, 16'h4000);
    do_reset();
    rr0 = 0;
    rr1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rr0 = !rr0;
      if ($urandom_range(0, 7) == 0) rr1 = !rr1;
      step(rr0, rnd_addr(), rr1, rnd_addr(), rnd_pc());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
